// File: rtl/id_ex_hazard_stage.sv
// ============================================================================
//  Module      : id_ex_hazard_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                one-cycle stall/bubble insertion and a saturating stall count.
//                Optional decode-slot flush is enabled by `define ID_EX_FLUSH_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Valid,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRd,
  input  logic              ID_UsesRt,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrc,
  input  logic [1:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExt,
  input  logic              ID_Flush,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_RegDst,
  output logic              ID_EX_ALUSrc,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_SignExt,
  output logic [CNT_W-1:0]  StallCount
);

  logic w_hz;
  logic w_flush;
  logic w_bubble;
  logic w_countStall;
  logic w_rsMatch;
  logic w_rtMatch;
  logic w_allowAdvance;

`ifdef ID_EX_FLUSH_EN
  assign w_flush = ID_Flush;
`else
  logic w_unusedFlush;
  assign w_unusedFlush = ID_Flush;
  assign w_flush       = 1'b0;
`endif

  // A load writing $0 produces nothing a consumer could wait on.
  assign w_rsMatch = (ID_EX_RegisterRt == IF_ID_RegisterRs);
  assign w_rtMatch = ID_UsesRt & (ID_EX_RegisterRt == IF_ID_RegisterRt);
  assign w_hz      = ID_Valid & ID_EX_MemRead & (ID_EX_RegisterRt != 5'd0)
                   & (w_rsMatch | w_rtMatch);

  assign w_allowAdvance = reset | w_flush | ~w_hz;
  assign PCWrite        = w_allowAdvance;
  assign IF_ID_Write    = w_allowAdvance;

  assign w_bubble     = w_flush | w_hz | ~ID_Valid;
  assign w_countStall = w_hz & ~w_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_MemWrite   <= 1'b0;
      ID_EX_MemtoReg   <= 1'b0;
      ID_EX_RegDst     <= 1'b0;
      ID_EX_ALUSrc     <= 1'b0;
      ID_EX_ALUOp      <= 2'b00;
      ID_EX_RegisterRs <= 5'd0;
      ID_EX_RegisterRt <= 5'd0;
      ID_EX_RegisterRd <= 5'd0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExt    <= '0;
      StallCount       <= '0;
    end else begin
      // Fields and data always advance; zero control alone makes a bubble.
      ID_EX_RegisterRs <= IF_ID_RegisterRs;
      ID_EX_RegisterRt <= IF_ID_RegisterRt;
      ID_EX_RegisterRd <= IF_ID_RegisterRd;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_SignExt    <= ID_SignExt;
      if (w_bubble) begin
        ID_EX_RegWrite <= 1'b0;
        ID_EX_MemRead  <= 1'b0;
        ID_EX_MemWrite <= 1'b0;
        ID_EX_MemtoReg <= 1'b0;
        ID_EX_RegDst   <= 1'b0;
        ID_EX_ALUSrc   <= 1'b0;
        ID_EX_ALUOp    <= 2'b00;
      end else begin
        ID_EX_RegWrite <= ID_RegWrite;
        ID_EX_MemRead  <= ID_MemRead;
        ID_EX_MemWrite <= ID_MemWrite;
        ID_EX_MemtoReg <= ID_MemtoReg;
        ID_EX_RegDst   <= ID_RegDst;
        ID_EX_ALUSrc   <= ID_ALUSrc;
        ID_EX_ALUOp    <= ID_ALUOp;
      end
      if (w_countStall && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
// ============================================================================
//  Module      : tb_id_ex_hazard_stage
//  Description : Scoreboard bench for id_ex_hazard_stage; directed and random
//                decode streams checked against a behavioural pipeline model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;
`ifdef ID_EX_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  // control byte layout: {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, ALUOp}
  localparam logic [7:0] LW_CTRL  = 8'b1101_0100;
  localparam logic [7:0] ALU_CTRL = 8'b1000_1010;

  typedef struct packed {
    logic [7:0]        ctrl;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] d1, d2, se;
  } ex_t;

  typedef struct {
    logic              rst, valid, usesRt, flush;
    logic [4:0]        rs, rt, rd;
    logic [7:0]        ctrl;
    logic [DATA_W-1:0] d1, d2, se;
  } stim_t;

  typedef struct {
    logic pc;
    ex_t  ex;
    int   cnt;
    bit   chkSat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, ID_Valid, ID_UsesRt, ID_Flush;
  logic [4:0]        IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd;
  logic              ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDst, ID_ALUSrc;
  logic [1:0]        ID_ALUOp;
  logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
  logic              PCWrite, IF_ID_Write;
  logic              ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_RegDst, ID_EX_ALUSrc;
  logic [1:0]        ID_EX_ALUOp;
  logic [4:0]        ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic [DATA_W-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExt;
  logic [CNT_W-1:0]  StallCount;

  id_ex_hazard_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ID_Valid(ID_Valid),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_RegisterRd(IF_ID_RegisterRd), .ID_UsesRt(ID_UsesRt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExt(ID_SignExt), .ID_Flush(ID_Flush),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExt(ID_EX_SignExt),
    .StallCount(StallCount)
  );

  exp_t  q[$];
  ex_t   model;
  int    modelCnt;
  bit    stimDone = 1'b0;
  int    checks   = 0;
  int    failures = 0;

  // Reference model: what the EX slot holds now, and the stall tally.
  function automatic bit loadUse(input ex_t e, input stim_t s);
    return s.valid && e.ctrl[6] && (e.rt != 5'd0) &&
           ((e.rt == s.rs) || (s.usesRt && (e.rt == s.rt)));
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst    = 1'b0;
    s.valid  = ($urandom_range(0, 9) != 0);
    s.rs     = 5'($urandom_range(0, 7));
    s.rt     = 5'($urandom_range(0, 7));
    s.rd     = 5'($urandom_range(0, 31));
    s.usesRt = 1'($urandom_range(0, 1));
    s.ctrl   = 8'($urandom);
    if ($urandom_range(0, 1) == 1) s.ctrl[6] = 1'b1;
    s.d1     = $urandom;
    s.d2     = $urandom;
    s.se     = $urandom;
    s.flush  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  function automatic stim_t mkStim(input logic [7:0] ctrl, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic usesRt);
    stim_t s;
    s = randStim();
    s.valid = 1'b1; s.flush = 1'b0;
    s.ctrl = ctrl; s.rs = rs; s.rt = rt; s.usesRt = usesRt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst; ID_Valid = s.valid; ID_UsesRt = s.usesRt; ID_Flush = s.flush;
    IF_ID_RegisterRs = s.rs; IF_ID_RegisterRt = s.rt; IF_ID_RegisterRd = s.rd;
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDst, ID_ALUSrc, ID_ALUOp} = s.ctrl;
    ID_ReadData1 = s.d1; ID_ReadData2 = s.d2; ID_SignExt = s.se;
  endtask

  task automatic apply(input stim_t s, input bit chkSat = 1'b0);
    exp_t e;
    bit   hz, fl;
    @(posedge clk); #1;
    drive(s);
    hz = loadUse(model, s);
    fl = FLUSH_EN && s.flush;
    e.pc = s.rst || fl || !hz;
    e.ex = model; e.cnt = modelCnt; e.chkSat = chkSat;
    q.push_back(e);
    if (s.rst) begin
      model = '0; modelCnt = 0;
    end else begin
      model = '{ctrl: s.ctrl, rs: s.rs, rt: s.rt, rd: s.rd, d1: s.d1, d2: s.d2, se: s.se};
      if (fl || hz || !s.valid) model.ctrl = 8'h00;
      if (hz && !fl && modelCnt < SAT) modelCnt = modelCnt + 1;
    end
  endtask

  initial begin
    stim_t s;
    model = '0; modelCnt = 0;
    s = randStim(); s.rst = 1'b1; s.valid = 1'b1; s.ctrl = 8'hFF; s.rs = 5'd9;
    drive(s);
    apply(s); apply(s);
    // pass-through
    s = mkStim(8'b1000_0010, 5'd3, 5'd4, 1'b1); s.rd = 5'd5; s.d1 = 32'h1234;
    apply(s);
    // load-use on rs, then the held instruction proceeds
    apply(mkStim(LW_CTRL, 5'd1, 5'd6, 1'b0));
    apply(mkStim(ALU_CTRL, 5'd6, 5'd2, 1'b1));
    apply(mkStim(ALU_CTRL, 5'd6, 5'd2, 1'b1));
    // rt gating and $0
    apply(mkStim(LW_CTRL, 5'd1, 5'd7, 1'b0));
    apply(mkStim(8'b1000_0100, 5'd1, 5'd7, 1'b0));
    apply(mkStim(LW_CTRL, 5'd1, 5'd7, 1'b0));
    apply(mkStim(ALU_CTRL, 5'd1, 5'd7, 1'b1));
    apply(mkStim(LW_CTRL, 5'd1, 5'd0, 1'b0));
    apply(mkStim(ALU_CTRL, 5'd0, 5'd0, 1'b1));
    // back-to-back loads, dependent third
    apply(mkStim(LW_CTRL, 5'd1, 5'd3, 1'b0));
    apply(mkStim(LW_CTRL, 5'd2, 5'd4, 1'b0));
    apply(mkStim(ALU_CTRL, 5'd4, 5'd3, 1'b1));
    apply(mkStim(ALU_CTRL, 5'd4, 5'd3, 1'b1));
    // flush coinciding with a load-use
    apply(mkStim(LW_CTRL, 5'd1, 5'd6, 1'b0));
    s = mkStim(ALU_CTRL, 5'd6, 5'd2, 1'b1); s.flush = 1'b1;
    apply(s);
    apply(mkStim(ALU_CTRL, 5'd6, 5'd2, 1'b1));
    for (int i = 0; i < 2000; i++) apply(randStim());
    // drive the counter into saturation
    for (int i = 0; i < SAT + 3; i++) begin
      apply(mkStim(LW_CTRL, 5'd1, 5'd6, 1'b0));
      apply(mkStim(ALU_CTRL, 5'd6, 5'd2, 1'b1));
    end
    s = randStim(); s.valid = 1'b0; s.flush = 1'b0;
    apply(s, 1'b1);
    apply(s);
    stimDone = 1'b1;
  end

  int idleCycles = 0;
  always @(negedge clk) begin
    exp_t e;
    ex_t  act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = '{ctrl: {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                     ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_ALUOp},
              rs: ID_EX_RegisterRs, rt: ID_EX_RegisterRt, rd: ID_EX_RegisterRd,
              d1: ID_EX_ReadData1, d2: ID_EX_ReadData2, se: ID_EX_SignExt};
      checks++;
      if (PCWrite !== e.pc) begin
        failures++;
        $display("FAIL pcwrite t=%0t got=%b want=%b", $time, PCWrite, e.pc);
      end
      checks++;
      if (IF_ID_Write !== e.pc) begin
        failures++;
        $display("FAIL ifidwrite t=%0t got=%b want=%b", $time, IF_ID_Write, e.pc);
      end
      checks++;
      if (act !== e.ex) begin
        failures++;
        $display("FAIL idex_regs t=%0t got=%h want=%h", $time, act, e.ex);
      end
      checks++;
      if (StallCount !== CNT_W'(e.cnt)) begin
        failures++;
        $display("FAIL stallcount t=%0t got=%0d want=%0d", $time, StallCount, e.cnt);
      end
      if (e.chkSat) begin
        checks++;
        if (StallCount !== CNT_W'(SAT)) begin
          failures++;
          $display("FAIL saturation t=%0t got=%0d want=%0d", $time, StallCount, SAT);
        end
      end
    end else if (stimDone) begin
      idleCycles++;
      if (idleCycles > 3) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
    if ($time > 1_000_000) begin
      failures++;
      $display("FAIL watchdog t=%0t pending=%0d want=0", $time, q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule

`default_nettype wire
